// File: rtl/smem_sched_pkg.sv
// Shared types and sizing helpers for the shared-memory bank scheduler.
package smem_sched_pkg;

  typedef enum logic {IDLE, ISSUE} state_e;

  function automatic int unsigned sel_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  function automatic int unsigned tid_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BANK_SEL_BITS = sel_bits(2);
  localparam int unsigned LINE_ADDR_W   = 30 - BANK_SEL_BITS;
  localparam int unsigned TID_W         = tid_bits(4);

endpackage

// File: rtl/smem_bank_pick.sv
// Per-bank lowest-lane priority select over the pending lanes, with
// same-address read merging (broadcast).
module smem_bank_pick import smem_sched_pkg::*; #(
  parameter int unsigned NUM_REQS         = 4,
  parameter int unsigned NUM_BANKS        = 2,
  parameter int unsigned WORD_ADDR_WIDTH  = 30,
  parameter int unsigned BANK_ADDR_OFFSET = 0
) (
  input  logic [NUM_REQS-1:0]                     pending,
  input  logic [NUM_REQS*WORD_ADDR_WIDTH-1:0]     addr,
  input  logic                                    rw,
  output logic [NUM_BANKS-1:0]                    bmask,
  output logic [NUM_BANKS*tid_bits(NUM_REQS)-1:0] tid,
  output logic [NUM_REQS-1:0]                     tmask
);

  localparam int unsigned AW   = WORD_ADDR_WIDTH;
  localparam int unsigned TIDW = tid_bits(NUM_REQS);

  function automatic logic [AW-1:0] bank_of(input logic [AW-1:0] a);
    return (a >> BANK_ADDR_OFFSET) & AW'(NUM_BANKS - 1);
  endfunction

  logic          found;
  logic [AW-1:0] win_addr;

  always_comb begin
    bmask    = '0;
    tid      = '0;
    tmask    = '0;
    found    = 1'b0;
    win_addr = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      found    = 1'b0;
      win_addr = '0;
      for (int unsigned r = 0; r < NUM_REQS; r++) begin
        if (pending[r] && !found && bank_of(addr[r*AW +: AW]) == AW'(b)) begin
          found                = 1'b1;
          win_addr             = addr[r*AW +: AW];
          bmask[b]             = 1'b1;
          tid[b*TIDW +: TIDW]  = TIDW'(r);
          tmask[r]             = 1'b1;
        end
      end
      // A matching full address is necessarily in this bank, so reads merge here
      if (found && !rw) begin
        for (int unsigned r = 0; r < NUM_REQS; r++) begin
          if (pending[r] && addr[r*AW +: AW] == win_addr) tmask[r] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/smem_bank_sched.sv
// Bank-conflict scheduler: captures one core request and issues it as a
// sequence of conflict-free bank batches.
module smem_bank_sched import smem_sched_pkg::*; #(
  parameter int unsigned NUM_REQS         = 4,
  parameter int unsigned NUM_BANKS        = 2,
  parameter int unsigned WORD_SIZE        = 4,
  parameter int unsigned WORD_ADDR_WIDTH  = 30,
  parameter int unsigned BANK_ADDR_OFFSET = 0,
  parameter int unsigned TAG_WIDTH        = 10,
  parameter int unsigned PERF_CTR_BITS    = 44
) (
  input  logic                                                        clk,
  input  logic                                                        reset,
  input  logic                                                        core_req_valid,
  input  logic [NUM_REQS-1:0]                                         core_req_tmask,
  input  logic                                                        core_req_rw,
  input  logic [NUM_REQS*WORD_ADDR_WIDTH-1:0]                         core_req_addr,
  input  logic [NUM_REQS*WORD_SIZE-1:0]                               core_req_byteen,
  input  logic [NUM_REQS*WORD_SIZE*8-1:0]                             core_req_data,
  input  logic [TAG_WIDTH-1:0]                                        core_req_tag,
  output logic                                                        core_req_ready,
  output logic                                                        bank_req_valid,
  output logic [NUM_BANKS-1:0]                                        bank_req_bmask,
  output logic                                                        bank_req_rw,
  output logic [NUM_BANKS*(WORD_ADDR_WIDTH-sel_bits(NUM_BANKS))-1:0]  bank_req_addr,
  output logic [NUM_BANKS*WORD_SIZE-1:0]                              bank_req_byteen,
  output logic [NUM_BANKS*WORD_SIZE*8-1:0]                            bank_req_data,
  output logic [NUM_BANKS*tid_bits(NUM_REQS)-1:0]                     bank_req_tid,
  output logic [NUM_REQS-1:0]                                         bank_req_tmask,
  output logic [TAG_WIDTH-1:0]                                        bank_req_tag,
  output logic                                                        bank_req_last,
  input  logic                                                        bank_req_ready,
  output logic [PERF_CTR_BITS-1:0]                                    perf_conflicts
);

  localparam int unsigned AW   = WORD_ADDR_WIDTH;
  localparam int unsigned BS   = sel_bits(NUM_BANKS);
  localparam int unsigned LW   = AW - BS;
  localparam int unsigned TIDW = tid_bits(NUM_REQS);
  localparam int unsigned WS   = WORD_SIZE;
  localparam int unsigned DW   = WORD_SIZE * 8;

  state_e                     state_q, state_d;
  logic [NUM_REQS-1:0]        pending_q, pending_d;
  logic                       rw_q, rw_d;
  logic [NUM_REQS*AW-1:0]     addr_q, addr_d;
  logic [NUM_REQS*WS-1:0]     byteen_q, byteen_d;
  logic [NUM_REQS*DW-1:0]     data_q, data_d;
  logic [TAG_WIDTH-1:0]       tag_q, tag_d;
  logic                       first_q, first_d;
  logic [PERF_CTR_BITS-1:0]   perf_q, perf_d;

  logic [NUM_BANKS-1:0]       pick_bmask;
  logic [NUM_BANKS*TIDW-1:0]  pick_tid;
  logic [NUM_REQS-1:0]        pick_tmask;
  logic                       valid, last, fire, accept;

  smem_bank_pick #(
    .NUM_REQS         (NUM_REQS),
    .NUM_BANKS        (NUM_BANKS),
    .WORD_ADDR_WIDTH  (WORD_ADDR_WIDTH),
    .BANK_ADDR_OFFSET (BANK_ADDR_OFFSET)
  ) u_pick (
    .pending (pending_q),
    .addr    (addr_q),
    .rw      (rw_q),
    .bmask   (pick_bmask),
    .tid     (pick_tid),
    .tmask   (pick_tmask)
  );

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    logic [AW-1:0] lo_mask;
    logic [AW-1:0] hi;
    lo_mask = (AW'(1) << BANK_ADDR_OFFSET) - AW'(1);
    hi      = (a >> (BANK_ADDR_OFFSET + BS)) << BANK_ADDR_OFFSET;
    return LW'(hi | (a & lo_mask));
  endfunction

  assign valid          = (state_q == ISSUE);
  assign last           = (pending_q & ~pick_tmask) == '0;
  assign fire           = valid && bank_req_ready;
  assign core_req_ready = reset && (!valid || (fire && last));
  assign accept         = core_req_valid && core_req_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    byteen_d  = byteen_q;
    data_d    = data_q;
    tag_d     = tag_q;
    first_d   = first_q;
    perf_d    = perf_q;
    if (fire) begin
      pending_d = pending_q & ~pick_tmask;
      first_d   = 1'b0;
      if (!first_q) perf_d = perf_q + PERF_CTR_BITS'(1);
      if (last) state_d = IDLE;
    end
    // Accept is only possible when idle or on a last fire, so it overrides the retire
    if (accept) begin
      pending_d = core_req_tmask;
      rw_d      = core_req_rw;
      addr_d    = core_req_addr;
      byteen_d  = core_req_byteen;
      data_d    = core_req_data;
      tag_d     = core_req_tag;
      first_d   = 1'b1;
      state_d   = (core_req_tmask != '0) ? ISSUE : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      byteen_q  <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      first_q   <= 1'b0;
      perf_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      byteen_q  <= byteen_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      first_q   <= first_d;
      perf_q    <= perf_d;
    end
  end

  always_comb begin
    bank_req_addr   = '0;
    bank_req_byteen = '0;
    bank_req_data   = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (pick_bmask[b]) begin
        bank_req_addr[b*LW +: LW]   = line_of(addr_q[int'(pick_tid[b*TIDW +: TIDW])*AW +: AW]);
        bank_req_byteen[b*WS +: WS] = byteen_q[int'(pick_tid[b*TIDW +: TIDW])*WS +: WS];
        bank_req_data[b*DW +: DW]   = data_q[int'(pick_tid[b*TIDW +: TIDW])*DW +: DW];
      end
    end
  end

  assign bank_req_valid = valid;
  assign bank_req_bmask = pick_bmask;
  assign bank_req_rw    = rw_q;
  assign bank_req_tid   = pick_tid;
  assign bank_req_tmask = pick_tmask;
  assign bank_req_tag   = tag_q;
  assign bank_req_last  = valid && last;
  assign perf_conflicts = perf_q;

endmodule

// File: tb/tb_smem_bank_sched.sv
// Randomized and directed bench for smem_bank_sched against a grouping model.
module tb_smem_bank_sched;

  localparam int NR = 4, NB = 2, AW = 30, WS = 4, DW = 32, TW = 10, PB = 44;
  localparam int OFF = 0, BS = 1, LW = AW - BS, TIDW = 2;

  logic              clk, reset;
  logic              core_req_valid, core_req_rw, core_req_ready;
  logic [NR-1:0]     core_req_tmask;
  logic [NR*AW-1:0]  core_req_addr;
  logic [NR*WS-1:0]  core_req_byteen;
  logic [NR*DW-1:0]  core_req_data;
  logic [TW-1:0]     core_req_tag;
  logic              bank_req_valid, bank_req_rw, bank_req_last, bank_req_ready;
  logic [NB-1:0]     bank_req_bmask;
  logic [NB*LW-1:0]  bank_req_addr;
  logic [NB*WS-1:0]  bank_req_byteen;
  logic [NB*DW-1:0]  bank_req_data;
  logic [NB*TIDW-1:0] bank_req_tid;
  logic [NR-1:0]     bank_req_tmask;
  logic [TW-1:0]     bank_req_tag;
  logic [PB-1:0]     perf_conflicts;

  smem_bank_sched #(
    .NUM_REQS(NR), .NUM_BANKS(NB), .WORD_SIZE(WS), .WORD_ADDR_WIDTH(AW),
    .BANK_ADDR_OFFSET(OFF), .TAG_WIDTH(TW), .PERF_CTR_BITS(PB)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_tmask(core_req_tmask),
    .core_req_rw(core_req_rw), .core_req_addr(core_req_addr),
    .core_req_byteen(core_req_byteen), .core_req_data(core_req_data),
    .core_req_tag(core_req_tag), .core_req_ready(core_req_ready),
    .bank_req_valid(bank_req_valid), .bank_req_bmask(bank_req_bmask),
    .bank_req_rw(bank_req_rw), .bank_req_addr(bank_req_addr),
    .bank_req_byteen(bank_req_byteen), .bank_req_data(bank_req_data),
    .bank_req_tid(bank_req_tid), .bank_req_tmask(bank_req_tmask),
    .bank_req_tag(bank_req_tag), .bank_req_last(bank_req_last),
    .bank_req_ready(bank_req_ready), .perf_conflicts(perf_conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0]         tmask;
    logic                  rw;
    logic [NR-1:0][AW-1:0] addr;
    logic [NR-1:0][WS-1:0] byteen;
    logic [NR-1:0][DW-1:0] data;
    logic [TW-1:0]         tag;
  } req_t;

  typedef struct packed {
    logic [NB-1:0]           bmask;
    logic [NB-1:0][TIDW-1:0] tid;
    logic [NR-1:0]           tmask;
    logic                    rw;
    logic [NB-1:0][LW-1:0]   addr;
    logic [NB-1:0][WS-1:0]   byteen;
    logic [NB-1:0][DW-1:0]   data;
    logic [TW-1:0]           tag;
    logic                    last;
    logic                    first;
  } batch_t;

  int        tests = 0, fails = 0;
  logic [PB-1:0] exp_perf = '0;
  req_t      req_q[$];
  batch_t    exp_q[$];

  function automatic int bank_of(input logic [AW-1:0] a);
    longint v = a;
    return int'((v / (2 ** OFF)) % NB);
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    longint v = a;
    return LW'((v / (2 ** (OFF + BS))) * (2 ** OFF) + v % (2 ** OFF));
  endfunction

  // Bank b's k-th batch is its k-th distinct read address (ordered by lowest
  // lane using it) or its k-th write lane; the request needs max-over-banks batches.
  function automatic void expand(input req_t rq);
    int cnt[NB];
    int lead[NB][NR];
    logic [NR-1:0] mem[NB][NR];
    int nb = 0, hit, b, l;
    batch_t e;
    for (int i = 0; i < NB; i++) cnt[i] = 0;
    for (int lane = 0; lane < NR; lane++) begin
      if (rq.tmask[lane]) begin
        b = bank_of(rq.addr[lane]);
        hit = -1;
        if (!rq.rw)
          for (int k = 0; k < cnt[b]; k++)
            if (rq.addr[lead[b][k]] == rq.addr[lane]) hit = k;
        if (hit >= 0) mem[b][hit][lane] = 1'b1;
        else begin
          lead[b][cnt[b]] = lane;
          mem[b][cnt[b]] = '0;
          mem[b][cnt[b]][lane] = 1'b1;
          cnt[b]++;
        end
      end
    end
    for (int i = 0; i < NB; i++) if (cnt[i] > nb) nb = cnt[i];
    for (int k = 0; k < nb; k++) begin
      e = '0;
      for (int i = 0; i < NB; i++) begin
        if (k < cnt[i]) begin
          l = lead[i][k];
          e.bmask[i]  = 1'b1;
          e.tid[i]    = TIDW'(l);
          e.tmask     = e.tmask | mem[i][k];
          e.addr[i]   = line_of(rq.addr[l]);
          e.byteen[i] = rq.byteen[l];
          e.data[i]   = rq.data[l];
        end
      end
      e.rw = rq.rw; e.tag = rq.tag;
      e.last = (k == nb - 1); e.first = (k == 0);
      exp_q.push_back(e);
    end
  endfunction

  function automatic req_t mk_req(input logic rw, input logic [NR-1:0] tm,
                                  input int a0, input int a1, input int a2, input int a3);
    req_t r;
    r.rw = rw; r.tmask = tm;
    r.addr[0] = AW'(a0); r.addr[1] = AW'(a1); r.addr[2] = AW'(a2); r.addr[3] = AW'(a3);
    for (int i = 0; i < NR; i++) begin
      r.byteen[i] = WS'($urandom);
      r.data[i]   = $urandom;
    end
    r.tag = TW'($urandom);
    return r;
  endfunction

  // Streams req_q into the DUT with valid held whenever a request waits,
  // checking every cycle against the queued expected batches.
  task automatic run_stream(input int stall_pct, input int stall_fire,
                            input int stall_len, input int max_cycles);
    int cycles = 0, fires = 0, stall_left = stall_len;
    bit exp_v, exp_rdy;
    batch_t e;
    while ((req_q.size() > 0 || exp_q.size() > 0) && cycles < max_cycles) begin
      @(negedge clk);
      if (fires == stall_fire && exp_q.size() > 0 && stall_left > 0) begin
        bank_req_ready = 1'b0; stall_left--;
      end else bank_req_ready = ($urandom_range(99) >= stall_pct);
      if (req_q.size() > 0) begin
        core_req_valid  = 1'b1;
        core_req_tmask  = req_q[0].tmask;
        core_req_rw     = req_q[0].rw;
        core_req_addr   = req_q[0].addr;
        core_req_byteen = req_q[0].byteen;
        core_req_data   = req_q[0].data;
        core_req_tag    = req_q[0].tag;
      end else core_req_valid = 1'b0;
      #1;
      exp_v = exp_q.size() > 0;
      exp_rdy = 1'b1;
      tests++;
      if (bank_req_valid !== exp_v) begin
        fails++; $display("FAIL valid: got %b expected %b (cycle %0d)", bank_req_valid, exp_v, cycles);
      end
      if (exp_v) begin
        e = exp_q[0];
        exp_rdy = e.last && bank_req_ready;
        tests += 5;
        if (bank_req_bmask !== e.bmask) begin fails++; $display("FAIL bmask: got %b expected %b", bank_req_bmask, e.bmask); end
        if (bank_req_tmask !== e.tmask) begin fails++; $display("FAIL tmask: got %b expected %b", bank_req_tmask, e.tmask); end
        if (bank_req_last !== e.last) begin fails++; $display("FAIL last: got %b expected %b", bank_req_last, e.last); end
        if (bank_req_rw !== e.rw) begin fails++; $display("FAIL rw: got %b expected %b", bank_req_rw, e.rw); end
        if (bank_req_tag !== e.tag) begin fails++; $display("FAIL tag: got %h expected %h", bank_req_tag, e.tag); end
        for (int b = 0; b < NB; b++) begin
          if (e.bmask[b]) begin
            tests += 4;
            if (bank_req_tid[b*TIDW +: TIDW] !== e.tid[b]) begin
              fails++; $display("FAIL tid%0d: got %0d expected %0d", b, bank_req_tid[b*TIDW +: TIDW], e.tid[b]);
            end
            if (bank_req_addr[b*LW +: LW] !== e.addr[b]) begin
              fails++; $display("FAIL addr%0d: got %h expected %h", b, bank_req_addr[b*LW +: LW], e.addr[b]);
            end
            if (bank_req_byteen[b*WS +: WS] !== e.byteen[b]) begin
              fails++; $display("FAIL byteen%0d: got %h expected %h", b, bank_req_byteen[b*WS +: WS], e.byteen[b]);
            end
            if (bank_req_data[b*DW +: DW] !== e.data[b]) begin
              fails++; $display("FAIL data%0d: got %h expected %h", b, bank_req_data[b*DW +: DW], e.data[b]);
            end
          end
        end
      end
      tests += 2;
      if (core_req_ready !== exp_rdy) begin
        fails++; $display("FAIL core_ready: got %b expected %b (cycle %0d)", core_req_ready, exp_rdy, cycles);
      end
      if (perf_conflicts !== exp_perf) begin
        fails++; $display("FAIL perf: got %0d expected %0d", perf_conflicts, exp_perf);
      end
      if (exp_v && bank_req_ready) begin
        if (!exp_q[0].first) exp_perf++;
        void'(exp_q.pop_front());
        fires++;
      end
      if (core_req_valid && exp_rdy) expand(req_q.pop_front());
      cycles++;
    end
    tests++;
    if (cycles >= max_cycles) begin
      fails++; $display("FAIL stream_timeout: got %0d cycles expected < %0d", cycles, max_cycles);
    end
    @(negedge clk);
    core_req_valid = 1'b0;
    bank_req_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; core_req_valid = 1'b0; bank_req_ready = 1'b1;
    core_req_tmask = '0; core_req_rw = 1'b0; core_req_addr = '0;
    core_req_byteen = '0; core_req_data = '0; core_req_tag = '0;
    repeat (2) @(negedge clk);
    #1;
    tests += 5;
    if (core_req_ready !== 1'b0) begin fails++; $display("FAIL rst_core_ready: got %b expected 0", core_req_ready); end
    if (bank_req_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", bank_req_valid); end
    if (perf_conflicts !== '0) begin fails++; $display("FAIL rst_perf: got %0d expected 0", perf_conflicts); end
    if (bank_req_bmask !== '0 || bank_req_tmask !== '0) begin
      fails++; $display("FAIL rst_masks: got %b/%b expected 0/0", bank_req_bmask, bank_req_tmask);
    end
    if (bank_req_last !== 1'b0) begin fails++; $display("FAIL rst_last: got %b expected 0", bank_req_last); end
    reset = 1'b1;
    @(negedge clk); #1;
    tests += 2;
    if (core_req_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready: got %b expected 1", core_req_ready); end
    if (bank_req_valid !== 1'b0) begin fails++; $display("FAIL post_rst_valid: got %b expected 0", bank_req_valid); end
  endtask

  task automatic test_single_batch;
    req_q.push_back(mk_req(1'b0, 4'b0011, 0, 1, 0, 0));
    run_stream(0, -1, 0, 50);
  endtask

  task automatic test_conflicts;
    req_q.push_back(mk_req(1'b0, 4'b1111, 0, 2, 4, 6));
    run_stream(0, -1, 0, 50);
  endtask

  task automatic test_broadcast;
    req_q.push_back(mk_req(1'b0, 4'b1111, 8, 8, 8, 8));
    run_stream(0, -1, 0, 50);
  endtask

  task automatic test_write_order;
    req_t r = mk_req(1'b1, 4'b0101, 4, 9, 4, 3);
    r.data[0] = 32'hA; r.data[2] = 32'hB;
    req_q.push_back(r);
    run_stream(0, -1, 0, 50);
  endtask

  task automatic test_zero_mask;
    req_q.push_back(mk_req(1'b0, 4'b0000, 1, 2, 3, 4));
    run_stream(0, -1, 0, 50);
    #1;
    tests += 2;
    if (bank_req_valid !== 1'b0) begin fails++; $display("FAIL zero_mask_valid: got %b expected 0", bank_req_valid); end
    if (core_req_ready !== 1'b1) begin fails++; $display("FAIL zero_mask_ready: got %b expected 1", core_req_ready); end
  endtask

  task automatic test_stall_back_to_back;
    req_q.push_back(mk_req(1'b0, 4'b1111, 0, 2, 4, 6));
    req_q.push_back(mk_req(1'b0, 4'b0011, 5, 2, 0, 0));
    run_stream(0, 1, 3, 60);
  endtask

  task automatic test_random;
    for (int n = 0; n < 150; n++)
      req_q.push_back(mk_req(1'($urandom), NR'($urandom), $urandom_range(7),
                             $urandom_range(7), $urandom_range(7), $urandom_range(7)));
    run_stream(30, -1, 0, 5000);
  endtask

  task automatic test_reset_mid;
    req_t r = mk_req(1'b0, 4'b1111, 0, 2, 4, 6);
    @(negedge clk);
    core_req_valid = 1'b1; core_req_tmask = r.tmask; core_req_rw = r.rw;
    core_req_addr = r.addr; core_req_byteen = r.byteen; core_req_data = r.data;
    core_req_tag = r.tag; bank_req_ready = 1'b1;
    @(negedge clk);
    core_req_valid = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (bank_req_valid !== 1'b1 || bank_req_tmask !== 4'b0010) begin
      fails++; $display("FAIL mid_batch2: got valid=%b tmask=%b expected 1/0010", bank_req_valid, bank_req_tmask);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    exp_perf = '0;
    exp_q.delete();
    tests += 5;
    if (bank_req_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b expected 0", bank_req_valid); end
    if (perf_conflicts !== '0) begin fails++; $display("FAIL mid_rst_perf: got %0d expected 0", perf_conflicts); end
    if (bank_req_bmask !== '0 || bank_req_tmask !== '0 || bank_req_last !== 1'b0) begin
      fails++; $display("FAIL mid_rst_ctrl: got %b/%b/%b expected 0/0/0", bank_req_bmask, bank_req_tmask, bank_req_last);
    end
    if (bank_req_addr !== '0 || bank_req_data !== '0 || bank_req_tag !== '0) begin
      fails++; $display("FAIL mid_rst_data: got %h/%h/%h expected 0", bank_req_addr, bank_req_data, bank_req_tag);
    end
    if (core_req_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready: got %b expected 0", core_req_ready); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests += 2;
      if (core_req_ready !== 1'b1) begin fails++; $display("FAIL rel_ready: got %b expected 1", core_req_ready); end
      if (bank_req_valid !== 1'b0) begin fails++; $display("FAIL rel_stale_valid: got %b expected 0", bank_req_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single_batch();
    test_conflicts();
    test_broadcast();
    test_write_order();
    test_zero_mask();
    test_stall_back_to_back();
    test_random();
    test_reset_mid();
    test_single_batch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
